spi_bus_arbiter: RTL
====================

SPI_BUS_ARBITER -- requirements
Module: spi_bus_arbiter

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset; ports clk and rst_n.
REQ-002 Parameter CLK_DIV, default 2: SCLK half-period in clk cycles, legal range 1..255.
REQ-003 Parameter N_SLAVES, default 4: number of chip selects, legal range 1..8.
REQ-004 clk  in  1  system clock; all state SHALL update on rising edge.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 req  in  2  per-requester transfer request, level, held until done for that requester.
REQ-007 tx_data0, tx_data1  in  8 each  byte to shift out, MSB first.
REQ-008 sel0, sel1  in  3 each  target slave index.
REQ-009 cpol0, cpha0, cpol1, cpha1  in  1 each  SPI mode per requester.
REQ-010 gnt  out  2  one-hot grant, high from acceptance until done.
REQ-011 rx_data  out  8  byte received on miso; valid while done is high and held until the next done.
REQ-012 done  out  1  one-cycle completion pulse; done_id (out, 1) names the finishing requester.
REQ-013 busy  out  1  high in any state other than IDLE.
REQ-014 sclk  out  1  SPI clock; mosi  out  1; miso  in  1; cs_n  out  N_SLAVES, active-low, at most one low.

Function
REQ-015 The FSM SHALL have exactly four states (IDLE, SETUP, XFER, HOLD), with transitions as follows.
- IDLE to SETUP: when any req is high.
- SETUP to XFER: after CLK_DIV cycles.
- XFER to HOLD: after 16 half-periods.
- HOLD to IDLE: after CLK_DIV cycles.
REQ-016 Arbitration in IDLE SHALL be round-robin.
- The requester not granted last wins a tie.
- The last-grant pointer resets to 1, so requester 0 wins the first tie.
REQ-017 On acceptance, the block SHALL latch tx_data, sel, cpol and cpha of the winner and set gnt for it.
- Inputs changing afterwards SHALL have no effect on the transfer.
REQ-018 In IDLE, sclk SHALL equal the registered cpol of the last transfer (0 after reset), cs_n SHALL be all ones, and mosi SHALL be 0.
REQ-019 SETUP behaviour:
- cs_n[sel] SHALL go low in the first SETUP cycle.
- sclk SHALL equal cpol.
- If cpha=0, mosi SHALL present tx bit 7.
REQ-020 In XFER, sclk SHALL toggle every CLK_DIV cycles, giving 16 edges; odd edges are leading edges and even edges are trailing edges.
REQ-021 cpha=0: miso SHALL be sampled on each leading edge; mosi SHALL shift to the next bit on each trailing edge except the 16th.
REQ-022 cpha=1: mosi SHALL shift on each leading edge, with the first leading edge presenting bit 7; miso SHALL be sampled on each trailing edge.
REQ-023 Received bits SHALL enter the shift register LSB-side, so the first sampled bit ends in rx_data[7].
REQ-024 HOLD behaviour:
- sclk SHALL stay at cpol and cs_n[sel] SHALL stay low.
- On exit, cs_n SHALL go all high, gnt SHALL clear, rx_data SHALL update and done SHALL pulse in the same cycle.
REQ-025 Latency: done SHALL rise exactly 18*CLK_DIV+1 clk cycles after the cycle in which gnt rises.
REQ-026 A req still high in the cycle after done SHALL be treated as a new request and arbitrated against the other requester.
- Back-to-back transfers SHALL therefore alternate when both requesters are pending.
REQ-027 A sel value of N_SLAVES or greater SHALL run the full transfer with all cs_n high and SHALL still pulse done.
REQ-028 A req that drops mid-transfer SHALL NOT abort the transfer.

Reset
REQ-029 When rst_n is asserted, at any time including mid-transfer, outputs SHALL immediately take these values:
- gnt=0, done=0, busy=0, rx_data=0, sclk=0, mosi=0, cs_n all ones.
REQ-030 On rst_n assertion, the FSM SHALL return to IDLE and the divider and bit counters SHALL clear.
- The next transfer after reset SHALL start cleanly from SETUP.

Structure
REQ-031 Package spi_pkg SHALL hold the FSM state enum, the MODE0..MODE3 constants and the 8-bit frame-width constant.
REQ-032 One sub-module, spi_edge_gen, SHALL provide the CLK_DIV divider and the edge counter.
- It SHALL output single-cycle lead_edge and trail_edge strobes and a last_edge flag.

Verification
REQ-033 Mode 0: CLK_DIV=2, req0 with tx_data0=0xA5, sel0=2, miso looped to mosi.
- cs_n=4'b1011, 8 rising sclk edges, rx_data=0xA5, done_id=0, done 37 cycles after gnt rises.
REQ-034 Mode 3: req1 with tx_data1=0x00, sel1=0, slave model returning 0x3C.
- sclk idles high, rx_data=0x3C, mosi changes only on falling sclk edges.
REQ-035 Both requesters pending: req0 and req1 raised in the same cycle after reset and held.
- Grant order SHALL be 0,1,0,1 and gnt SHALL never be 2'b11.
REQ-036 Reset mid-transfer: rst_n pulled low at the 5th sclk edge.
- cs_n SHALL be all ones and sclk=0 in the same cycle, with no done.
- A following request SHALL complete normally.
REQ-037 Out-of-range select: sel0=5 with N_SLAVES=4.
- cs_n SHALL stay 4'b1111 throughout and done SHALL pulse at the normal latency.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared types and constants for the two-requester SPI bus arbiter.
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        XFER  = 2'd2,
        HOLD  = 2'd3
    } state_e;

    // SPI mode encoding is {cpol, cpha}
    localparam logic [1:0] MODE0 = 2'b00;
    localparam logic [1:0] MODE1 = 2'b01;
    localparam logic [1:0] MODE2 = 2'b10;
    localparam logic [1:0] MODE3 = 2'b11;

    localparam int unsigned FRAME_W = 8;

endpackage

// File: rtl/spi_edge_gen.sv
// CLK_DIV half-period divider and SCLK edge counter; strobes mark the clk
// cycle at whose end the corresponding sclk edge is launched.
module spi_edge_gen
    import spi_pkg::*;
#(
    parameter int unsigned CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    input  logic xfer,
    output logic tick,
    output logic lead_edge,
    output logic trail_edge,
    output logic last_edge
);

    localparam logic [7:0] DIV_LAST  = 8'(CLK_DIV - 1);
    localparam logic [3:0] EDGE_LAST = 4'(2 * FRAME_W - 1);

    logic [7:0] div_q, div_d;
    logic [3:0] edge_q, edge_d;

    assign tick = run && (div_q == DIV_LAST);

    always_comb begin
        div_d  = div_q;
        edge_d = edge_q;
        if (!run || tick) begin
            div_d = '0;
        end else begin
            div_d = div_q + 8'd1;
        end
        if (!xfer) begin
            edge_d = '0;
        end else if (tick) begin
            edge_d = edge_q + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q  <= '0;
            edge_q <= '0;
        end else begin
            div_q  <= div_d;
            edge_q <= edge_d;
        end
    end

    // edge_q counts completed edges, so an even count means the next is odd (leading)
    assign lead_edge  = xfer && tick && !edge_q[0];
    assign trail_edge = xfer && tick &&  edge_q[0];
    assign last_edge  = (edge_q == EDGE_LAST);

endmodule

// File: rtl/spi_bus_arbiter.sv
// Round-robin arbiter granting one of two requesters an SPI master that
// runs one 8-bit frame to a selected slave, then pulses done.
module spi_bus_arbiter
    import spi_pkg::*;
#(
    parameter int unsigned CLK_DIV  = 2,
    parameter int unsigned N_SLAVES = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [1:0]          req,
    input  logic [7:0]          tx_data0,
    input  logic [7:0]          tx_data1,
    input  logic [2:0]          sel0,
    input  logic [2:0]          sel1,
    input  logic                cpol0,
    input  logic                cpha0,
    input  logic                cpol1,
    input  logic                cpha1,
    output logic [1:0]          gnt,
    output logic [7:0]          rx_data,
    output logic                done,
    output logic                done_id,
    output logic                busy,
    output logic                sclk,
    output logic                mosi,
    input  logic                miso,
    output logic [N_SLAVES-1:0] cs_n
);

    state_e               state_q, state_d;
    logic                 last_q, last_d;
    logic                 id_q, id_d;
    logic [1:0]           gnt_q, gnt_d;
    logic [FRAME_W-1:0]   tx_q, tx_d;
    logic [FRAME_W-1:0]   rxsh_q, rxsh_d;
    logic [FRAME_W-1:0]   rx_q, rx_d;
    logic [2:0]           sel_q, sel_d;
    logic                 cpol_q, cpol_d;
    logic                 cpha_q, cpha_d;
    logic                 sclk_q, sclk_d;
    logic                 started_q, started_d;
    logic                 hold_done_q, hold_done_d;
    logic                 done_q, done_d;
    logic                 done_id_q, done_id_d;

    logic tick, lead_edge, trail_edge, last_edge;
    logic win;

    spi_edge_gen #(.CLK_DIV(CLK_DIV)) u_edge_gen (
        .clk        (clk),
        .rst_n      (rst_n),
        .run        (state_q != IDLE),
        .xfer       (state_q == XFER),
        .tick       (tick),
        .lead_edge  (lead_edge),
        .trail_edge (trail_edge),
        .last_edge  (last_edge)
    );

    always_comb begin
        if (req == 2'b11) win = ~last_q;
        else              win = ~req[0];
    end

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        id_d        = id_q;
        gnt_d       = gnt_q;
        tx_d        = tx_q;
        rxsh_d      = rxsh_q;
        rx_d        = rx_q;
        sel_d       = sel_q;
        cpol_d      = cpol_q;
        cpha_d      = cpha_q;
        sclk_d      = sclk_q;
        started_d   = started_q;
        hold_done_d = hold_done_q;
        done_d      = 1'b0;
        done_id_d   = done_id_q;
        case (state_q)
            IDLE: begin
                // the done cycle is skipped so a still-high req re-arbitrates a cycle later
                if (|req && !done_q) begin
                    state_d   = SETUP;
                    last_d    = win;
                    id_d      = win;
                    gnt_d     = win ? 2'b10 : 2'b01;
                    tx_d      = win ? tx_data1 : tx_data0;
                    sel_d     = win ? sel1 : sel0;
                    cpol_d    = win ? cpol1 : cpol0;
                    cpha_d    = win ? cpha1 : cpha0;
                    sclk_d    = win ? cpol1 : cpol0;
                    started_d = 1'b0;
                    rxsh_d    = '0;
                end
            end
            SETUP: begin
                if (tick) state_d = XFER;
            end
            XFER: begin
                if (lead_edge || trail_edge) sclk_d = ~sclk_q;
                if (lead_edge) begin
                    if (!cpha_q)        rxsh_d    = {rxsh_q[FRAME_W-2:0], miso};
                    else if (started_q) tx_d      = {tx_q[FRAME_W-2:0], 1'b0};
                    else                started_d = 1'b1;
                end
                if (trail_edge) begin
                    if (cpha_q)          rxsh_d = {rxsh_q[FRAME_W-2:0], miso};
                    else if (!last_edge) tx_d   = {tx_q[FRAME_W-2:0], 1'b0};
                    if (last_edge) begin
                        state_d     = HOLD;
                        hold_done_d = 1'b0;
                    end
                end
            end
            HOLD: begin
                // CLK_DIV hold cycles plus the exit cycle give the 18*CLK_DIV+1 latency
                if (tick) hold_done_d = 1'b1;
                if (hold_done_q) begin
                    state_d   = IDLE;
                    gnt_d     = 2'b00;
                    rx_d      = rxsh_q;
                    done_d    = 1'b1;
                    done_id_d = id_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            last_q      <= 1'b1;
            id_q        <= 1'b0;
            gnt_q       <= '0;
            tx_q        <= '0;
            rxsh_q      <= '0;
            rx_q        <= '0;
            sel_q       <= '0;
            cpol_q      <= 1'b0;
            cpha_q      <= 1'b0;
            sclk_q      <= 1'b0;
            started_q   <= 1'b0;
            hold_done_q <= 1'b0;
            done_q      <= 1'b0;
            done_id_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            id_q        <= id_d;
            gnt_q       <= gnt_d;
            tx_q        <= tx_d;
            rxsh_q      <= rxsh_d;
            rx_q        <= rx_d;
            sel_q       <= sel_d;
            cpol_q      <= cpol_d;
            cpha_q      <= cpha_d;
            sclk_q      <= sclk_d;
            started_q   <= started_d;
            hold_done_q <= hold_done_d;
            done_q      <= done_d;
            done_id_q   <= done_id_d;
        end
    end

    always_comb begin
        cs_n = '1;
        for (int unsigned i = 0; i < N_SLAVES; i++) begin
            if (state_q != IDLE && {29'd0, sel_q} == i) cs_n[i] = 1'b0;
        end
    end

    always_comb begin
        mosi = 1'b0;
        if (state_q != IDLE) mosi = cpha_q ? (started_q & tx_q[FRAME_W-1]) : tx_q[FRAME_W-1];
    end

    assign gnt     = gnt_q;
    assign rx_data = rx_q;
    assign done    = done_q;
    assign done_id = done_id_q;
    assign busy    = (state_q != IDLE);
    assign sclk    = sclk_q;

endmodule
